// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined parameterised carry-lookahead add/subtract unit
// Ports: clock/reset_n (async active-low); in_valid/in_ready with in_a, in_b,
// in_cin, in_sub, in_tag; out_valid/out_ready with out_sum, out_cout, out_ovf,
// out_zero, out_tag. One WIDTH/STAGES-bit slice is resolved per stage.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  input  logic              in_sub,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int S  = WIDTH / STAGES;
  localparam int NG = S / BLOCK;
  localparam int L  = STAGES - 1;

  // Two-level lookahead over one slice: bit G/P -> group G/P -> group carries
  // (fully expanded sum-of-products, no ripple) -> bit carries inside groups.
  // Returns {carry_out, sum}.
  function automatic logic [S:0] cla_slice(input logic [S-1:0] a,
                                           input logic [S-1:0] b,
                                           input logic         cin);
    logic [S-1:0]  g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          t;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        t = g[j*BLOCK+i];
        for (int n = i + 1; n < BLOCK; n++) t = t & p[j*BLOCK+n];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      t = cin;
      for (int n = 0; n <= j; n++) t = t & gp[n];
      gc[j+1] = t;
      for (int m = 0; m <= j; m++) begin
        t = gg[m];
        for (int n = m + 1; n <= j; n++) t = t & gp[n];
        gc[j+1] = gc[j+1] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        t = gc[j];
        for (int n = 0; n < i; n++) t = t & p[j*BLOCK+n];
        c[j*BLOCK+i] = t;
        for (int m = 0; m < i; m++) begin
          t = g[j*BLOCK+m];
          for (int n = m + 1; n < i; n++) t = t & p[j*BLOCK+n];
          c[j*BLOCK+i] = c[j*BLOCK+i] | t;
        end
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  // Stage registers. Operand bits below the next slice are dead once summed.
  logic [STAGES-1:0] st_valid;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [STAGES-1:0] st_c;
  logic [TAG_W-1:0]  st_tag [STAGES];
  logic              r_ovf, r_zero;

  // Per-stage sources: stage 0 is fed from the ports, stage k from stage k-1.
  logic [WIDTH-1:0]  sa   [STAGES];
  logic [WIDTH-1:0]  sb   [STAGES];
  logic [WIDTH-1:0]  ssum [STAGES];
  logic [WIDTH-1:0]  nsum [STAGES];
  logic [TAG_W-1:0]  stag [STAGES];
  logic [STAGES-1:0] sc, nc;
  logic [S:0]        res;
  logic              fin_cmsb, fin_ovf, fin_zero;
  logic [STAGES-1:0] adv, load;

  always_comb begin
    res      = '0;
    sa[0]    = in_a;
    sb[0]    = in_sub ? ~in_b : in_b;
    sc       = '0;
    sc[0]    = in_sub | in_cin;
    ssum[0]  = '0;
    stag[0]  = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      sa[k]   = st_a[k-1];
      sb[k]   = st_b[k-1];
      sc[k]   = st_c[k-1];
      ssum[k] = st_sum[k-1];
      stag[k] = st_tag[k-1];
    end
    nc = '0;
    for (int k = 0; k < STAGES; k++) begin
      res                = cla_slice(sa[k][k*S +: S], sb[k][k*S +: S], sc[k]);
      nsum[k]            = ssum[k];
      nsum[k][k*S +: S]  = res[S-1:0];
      nc[k]              = res[S];
    end
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    fin_cmsb = sa[L][WIDTH-1] ^ sb[L][WIDTH-1] ^ nsum[L][WIDTH-1];
    fin_ovf  = fin_cmsb ^ nc[L];
    fin_zero = (nsum[L] == '0);
  end

  // Advance resolves from the output back so bubbles collapse under stall.
  always_comb begin
    adv    = '0;
    load   = '0;
    adv[L] = st_valid[L] & out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      adv[k] = st_valid[k] & (~st_valid[k+1] | adv[k+1]);
    end
    in_ready = reset_n & (~st_valid[0] | adv[0]);
    load[0]  = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) load[k] = adv[k-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_valid <= '0;
      st_c     <= '0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
        st_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k] <= load[k] | (st_valid[k] & ~adv[k]);
        if (load[k]) begin
          st_a[k]   <= sa[k];
          st_b[k]   <= sb[k];
          st_sum[k] <= nsum[k];
          st_c[k]   <= nc[k];
          st_tag[k] <= stag[k];
        end
      end
      if (load[L]) begin
        r_ovf  <= fin_ovf;
        r_zero <= fin_zero;
      end
    end
  end

  assign out_valid = st_valid[L];
  assign out_sum   = st_sum[L];
  assign out_cout  = st_c[L];
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;
  assign out_tag   = st_tag[L];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int BLOCK  = 8;
  localparam int TAG_W  = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic              in_cin = 1'b0;
  logic              in_sub = 1'b0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_sum;
  logic              out_cout, out_ovf, out_zero;
  logic [TAG_W-1:0]  out_tag;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .BLOCK(BLOCK), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  typedef struct packed {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } vec_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_lat = 0;
  bit   rdone = 0;
  bit   stalled = 0;
  logic [39:0] snap;

  // Plain integer arithmetic: unsigned result/carry, signed range for overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub,
                                 input logic [3:0] tag, input int acc);
    exp_t   r;
    longint ua, ub, sa, sb, ci, rs;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    ci = cin ? 1 : 0;
    if (!sub) begin
      r.sum  = a + b + {31'b0, cin};
      r.cout = (ua + ub + ci) >= 64'sd4294967296;
      rs     = sa + sb + ci;
    end else begin
      r.sum  = a - b;
      r.cout = (a >= b);
      rs     = sa - sb;
    end
    r.ovf  = (rs > SMAX) || (rs < SMIN);
    r.zero = (r.sum == 32'h0);
    r.tag  = tag;
    r.acc  = acc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard and stall-stability checks, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      stalled = 0;
    end else begin
      if (stalled) begin
        n_vec++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== {1'b1, snap[38:0]}) begin
          n_bad++;
          $display("FAIL stall_hold actual=%h required=%h",
                   {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}, {1'b1, snap[38:0]});
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_out actual sum=%h tag=%h required no output", out_sum, out_tag);
        end else begin
          e = q.pop_front();
          if ({out_sum, out_cout, out_ovf, out_zero, out_tag} !== {e.sum, e.cout, e.ovf, e.zero, e.tag}) begin
            n_bad++;
            $display("FAIL result actual sum=%h c=%b v=%b z=%b tag=%h required sum=%h c=%b v=%b z=%b tag=%h",
                     out_sum, out_cout, out_ovf, out_zero, out_tag, e.sum, e.cout, e.ovf, e.zero, e.tag);
          end
          if (chk_lat) begin
            n_vec++;
            if (cyc - e.acc != STAGES) begin
              n_bad++;
              $display("FAIL latency actual=%0d required=%0d", cyc - e.acc, STAGES);
            end
          end
        end
      end
      if (out_valid && !out_ready) begin
        stalled = 1;
        snap = {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag};
      end else begin
        stalled = 0;
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag, cyc));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input logic [3:0] tag);
    bit acc;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
    acc = 0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    chk("send_accept", {63'b0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_left", q.size(), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t dv[12];
  exp_t m;

  initial begin
    dv[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    dv[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    dv[2]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    dv[3]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    dv[4]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    dv[5]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    dv[6]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    dv[7]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    dv[8]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
    dv[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    dv[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    dv[11] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}, 64'd0);
    chk("rst_in_ready_low", {63'b0, in_ready}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready_high", {63'b0, in_ready}, 64'd1);
    @(posedge clock);
    #1;

    // Directed vectors, back-to-back, literal expectations pin the model
    chk_lat = 1;
    for (int i = 0; i < 12; i++) begin
      m = model(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, 4'(i), 0);
      chk($sformatf("model_v%0d", i), {m.sum, m.cout, m.ovf, m.zero},
          {dv[i].sum, dv[i].cout, dv[i].ovf, dv[i].zero});
      send(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, 4'(i));
    end
    drain();
    chk_lat = 0;

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'hA);
    send(32'h00000005, 32'h00000003, 1'b0, 1'b1, 4'hB);
    chk("inflight_valid", {63'b0, out_valid}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("rel_in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rel_no_stale", {63'b0, out_valid}, 64'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1;

    // Backpressure: six ops, output stalled four cycles mid-stream
    fork
      begin
        for (int t = 0; t < 6; t++)
          send(32'h1000_0000 * t + 32'h0000_FFFF, 32'(t + 1), 1'b0, 1'(t % 2), 4'(t));
      end
      begin
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        @(posedge clock);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clock);
          chk("bp_rate", {63'b0, out_valid}, 64'd1);
        end
      end
    join
    drain();

    // Random operands with edge values, random gaps and random backpressure
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clock);
            #1;
          end
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clock);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
